// File: rtl/m_bcd_conv_seq_if.sv
// Handshake bundle for the sequential binary-to-BCD converter: request side
// (in_valid/in_ready/bin) and result side (out_valid/out_ready/bcd/ovf/lz_mask).
interface m_bcd_conv_seq_if #(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd;
  logic                  ovf;
  logic [DIGITS-1:0]     lz_mask;

  modport master (
    output in_valid, bin, out_ready,
    input  in_ready, busy, out_valid, bcd, ovf, lz_mask
  );

  modport slave (
    input  in_valid, bin, out_ready,
    output in_ready, busy, out_valid, bcd, ovf, lz_mask
  );
endinterface

// File: rtl/m_bcd_conv_seq.sv
// Iterative double-dabble binary-to-BCD converter, one input bit per clock,
// with valid/ready on both sides, sticky overflow and a leading-zero mask.
module m_bcd_conv_seq #(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  m_bcd_conv_seq_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam int unsigned BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   sr_q, sr_d;
  logic [BCD_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               acc_ovf_q, acc_ovf_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;

  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   acc_shift;
  logic               ovf_bit;
  logic [DIGITS-1:0]  lz;

  // Add-3 correction on every digit in parallel before the shift.
  always_comb begin
    adj = acc_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  assign acc_shift = {adj[BCD_W-2:0], sr_q[BIN_W-1]};
  assign ovf_bit   = adj[BCD_W-1];

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    acc_ovf_d = acc_ovf_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d   = SHIFT;
          sr_d      = bus.bin;
          acc_d     = '0;
          acc_ovf_d = 1'b0;
          cnt_d     = CNT_W'(BIN_W);
        end
      end
      SHIFT: begin
        sr_d      = sr_q << 1;
        acc_d     = acc_shift;
        acc_ovf_d = acc_ovf_q | ovf_bit;
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          bcd_d   = acc_shift;
          ovf_d   = acc_ovf_q | ovf_bit;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      acc_ovf_q   <= 1'b0;
      bcd_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      acc_ovf_q   <= acc_ovf_d;
      bcd_q       <= bcd_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Scan from the top digit down; a bit stays set while everything above is zero.
  always_comb begin
    logic zero_above;
    lz         = '0;
    zero_above = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      zero_above              = zero_above && (bcd_q[4*(DIGITS-1-k) +: 4] == 4'd0);
      lz[DIGITS-1-k]          = zero_above;
    end
    lz[0] = 1'b0;
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q == SHIFT);
  assign bus.out_valid = out_valid_q;
  assign bus.bcd       = bcd_q;
  assign bus.ovf       = ovf_q;
  assign bus.lz_mask   = lz;
endmodule
